iterative_rotate_unit: RTL and testbench
========================================

# iterative_rotate_unit

Multi-cycle 16-bit rotate engine for the 8088 ALU datapath. It executes ROL/ROR/RCL/RCR with the full 8-bit CL count, one bit position per clock, as the 8088 microsequencer does. This is the sequential counterpart of the single-cycle rotate block, which handles only 1..15 positions. It sits between the execution-unit sequencer (start/done handshake) and the flags/register write-back path.

## Interface

Parameters:
- none (width fixed at 16 bits, count fixed at 8 bits)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- start  in  1  request; sampled only in IDLE
- A  in  16  operand, latched when start is accepted
- count  in  8  rotate count (CL or 1), latched on accept, not masked
- op  in  2  00 ROL, 01 ROR, 10 RCL, 11 RCR, latched on accept
- Cin  in  1  incoming carry flag, latched on accept
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; R/CF/OF/flag_upd valid in that cycle
- R  out  16  result
- CF  out  1  carry-out
- OF  out  1  overflow
- flag_upd  out  1  1 = write CF/OF; 0 = leave flags unchanged (count was 0)

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 latches A→acc, count→cnt, op, Cin→c, orig15=A[15].
  - Next state is RUN if count≠0, else DONE.
- RUN: one single-bit step per cycle on {acc, c}, then cnt decrements. Steps by op:
  - ROL: acc={acc[14:0],acc[15]}, c=acc[15].
  - ROR: acc={acc[0],acc[15:1]}, c=acc[0].
  - RCL: rotates 17-bit {c,acc} left by one.
  - RCR: rotates 17-bit {acc,c} right by one.
  - When cnt reaches 0 after its step, next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Output values:
  - R=acc and CF=c.
  - OF=orig15 XOR R[15].
  - flag_upd=1 if the latched count≠0.
- Count 0: R=A, CF=Cin, OF=0, flag_upd=0.
- Counts ≥16 (≥17 for RCL/RCR) wrap naturally by iteration. No modulo shortcut is used; cycle cost is always count steps.
- R, CF, OF and flag_upd hold their values after DONE until the next accepted start.
- start while busy=1 is ignored, with no queuing. Latched operands are unaffected by input changes during RUN.

## Timing

- Accept edge = cycle 0.
- Count N≥1:
  - RUN occupies cycles 1..N.
  - done=1 in cycle N+1.
  - Total latency is N+1 cycles, maximum 256.
- Count 0: done=1 in cycle 1.
- Back-to-back: the earliest new start is accepted in the cycle after done, with IDLE sampling it.
- Reset (rst_n=0 at an edge), from any state including mid-RUN:
  - State goes to IDLE.
  - busy=0, done=0, R=0x0000, CF=0, OF=0, flag_upd=0; internal cnt/acc/c cleared.
  - No done pulse is generated for the aborted operation.
- start and rst_n low in the same edge: reset wins.

## Test plan

- ROL, A=0x8001, count=1:
  - done in cycle 2.
  - R=0x0003, CF=1, OF=1, flag_upd=1.
- RCR, A=0x0001, Cin=0, count=1:
  - R=0x0000, CF=1, OF=0.
- RCL, A=0x1234, Cin=1, count=17:
  - Full 17-bit wrap gives R=0x1234, CF=1, OF=0.
  - done in cycle 18; busy high cycles 1..18.
- ROR, A=0x0001, count=255:
  - R=0x0002, CF=0, OF=0.
  - done in cycle 256.
- ROL, A=0xBEEF, Cin=1, count=0:
  - done in cycle 1.
  - R=0xBEEF, CF=1, OF=0, flag_upd=0.
- Robustness:
  - Pulse start with new operands during RUN of a count=8 ROL: ignored, and the result matches the original operands.
  - Drive rst_n=0 at cycle 4 of a count=10 op: next cycle busy=0, R=0, no done.
  - A fresh start after reset completes normally.

Source files
------------

// File: rtl/iterative_rotate_unit_if.sv
// Start/done bus between the execution-unit sequencer and the iterative rotate engine.
// Operand fields carry the 8088 names; dbg_state exposes the engine FSM for checkers.
interface iterative_rotate_unit_if;
  logic        start;
  logic [15:0] A;
  logic [7:0]  count;
  logic [1:0]  op;
  logic        Cin;
  logic        busy;
  logic        done;
  logic [15:0] R;
  logic        CF;
  logic        OF;
  logic        flag_upd;
  logic [1:0]  dbg_state;

  modport master (
    output start, A, count, op, Cin,
    input  busy, done, R, CF, OF, flag_upd, dbg_state
  );

  modport slave (
    input  start, A, count, op, Cin,
    output busy, done, R, CF, OF, flag_upd, dbg_state
  );
endinterface

// File: rtl/iterative_rotate_unit.sv
// Multi-cycle 16-bit ROL/ROR/RCL/RCR engine: one bit position per clock, full 8-bit count.
// Handshake: start is accepted only while busy=0; done pulses once with results valid, then R/CF/OF/flag_upd hold.
module iterative_rotate_unit (
  input  logic                    clk,
  input  logic                    rst_n,
  iterative_rotate_unit_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic        c_q, c_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        orig15_q, orig15_d;
  logic        upd_q, upd_d;
  logic        accept;

  assign accept = (state_q == S_IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (bus.count != 8'd0) ? S_RUN : S_DONE;
      S_RUN:   if (cnt_q == 8'd1) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: load on accept, otherwise one single-bit rotate of {c,acc} per RUN cycle.
  always_comb begin
    acc_d    = acc_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    orig15_d = orig15_q;
    upd_d    = upd_q;
    if (accept) begin
      acc_d    = bus.A;
      c_d      = bus.Cin;
      cnt_d    = bus.count;
      op_d     = bus.op;
      orig15_d = bus.A[15];
      upd_d    = (bus.count != 8'd0);
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q - 8'd1;
      case (op_q)
        2'b00: begin acc_d = {acc_q[14:0], acc_q[15]}; c_d = acc_q[15]; end
        2'b01: begin acc_d = {acc_q[0], acc_q[15:1]};  c_d = acc_q[0];  end
        2'b10: begin acc_d = {acc_q[14:0], c_q};       c_d = acc_q[15]; end
        default: begin acc_d = {c_q, acc_q[15:1]};     c_d = acc_q[0];  end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= 16'h0000;
      c_q      <= 1'b0;
      cnt_q    <= 8'd0;
      op_q     <= 2'b00;
      orig15_q <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      orig15_q <= orig15_d;
      upd_q    <= upd_d;
    end
  end

  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.R         = acc_q;
    bus.CF        = c_q;
    bus.OF        = orig15_q ^ acc_q[15];
    bus.flag_upd  = upd_q;
    bus.dbg_state = state_q;
  end
endmodule

// File: tb/tb_iterative_rotate_unit.sv
// Bench for iterative_rotate_unit: directed cases, robustness cases and random ops
// checked against a closed-form rotate model.
module tb_iterative_rotate_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic [18:0] exp_q[$];

  iterative_rotate_unit_if bus();

  iterative_rotate_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Closed-form model: 16-bit or 17-bit ring rotated by count modulo the ring size.
  function automatic logic [18:0] ref_model(input logic [1:0] op, input logic [15:0] a,
                                            input logic [7:0] cnt, input logic cin);
    logic [31:0] d;
    logic [33:0] e;
    logic [16:0] v;
    logic [15:0] r;
    logic        cf;
    int          n;
    v = {cin, a};
    case (op)
      2'b00: begin
        n = int'(cnt) % 16; d = {a, a} << n; r = d[31:16];
        cf = (cnt == 8'd0) ? cin : r[0];
      end
      2'b01: begin
        n = int'(cnt) % 16; d = {a, a} >> n; r = d[15:0];
        cf = (cnt == 8'd0) ? cin : r[15];
      end
      2'b10: begin
        n = int'(cnt) % 17; e = {v, v} << n; v = e[33:17];
        r = v[15:0]; cf = v[16];
      end
      default: begin
        n = int'(cnt) % 17; e = {v, v} >> n; v = e[16:0];
        r = v[15:0]; cf = v[16];
      end
    endcase
    return {r, cf, a[15] ^ r[15], cnt != 8'd0};
  endfunction

  // driver: issue one op, follow it to done, score it
  task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [7:0] cnt,
                       input logic cin, input bit interfere);
    int          cyc;
    int          busy_low;
    logic [18:0] e;
    @(negedge clk);
    bus.op = op; bus.A = a; bus.count = cnt; bus.Cin = cin; bus.start = 1'b1;
    exp_q.push_back(ref_model(op, a, cnt, cin));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = 16'($urandom); bus.count = 8'($urandom); bus.op = 2'($urandom); bus.Cin = 1'($urandom);
    busy_low = 0;
    for (cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (!bus.busy) busy_low++;
      if (bus.done) break;
      if (interfere && cyc == 3) begin
        bus.start = 1'b1; bus.A = ~a; bus.op = op + 2'd1; bus.count = 8'd1; bus.Cin = ~cin;
      end
      if (interfere && cyc == 4) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    chk("latency", cyc, (cnt == 8'd0) ? 1 : int'(cnt) + 1);
    chk("busy_during_op", busy_low, 0);
    e = exp_q.pop_front();
    chk("R", bus.R, e[18:3]);
    chk("CF", bus.CF, e[2]);
    chk("OF", bus.OF, e[1]);
    chk("flag_upd", bus.flag_upd, e[0]);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 1'b0);
    chk("busy_after", bus.busy, 1'b0);
    chk("R_hold", bus.R, e[18:3]);
  endtask

  initial begin
    int          dcount;
    logic [7:0]  rc;
    rst_n = 1'b0;
    bus.start = 1'b1; bus.A = 16'hFFFF; bus.count = 8'd5; bus.op = 2'b00; bus.Cin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_R", bus.R, 16'h0000);
    chk("rst_CF", bus.CF, 1'b0);
    chk("rst_OF", bus.OF, 1'b0);
    chk("rst_flag_upd", bus.flag_upd, 1'b0);
    chk("rst_state", bus.dbg_state, 2'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;

    do_op(2'b00, 16'h8001, 8'd1, 1'b0, 1'b0);
    chk("tp_rol_R", bus.R, 16'h0003);
    chk("tp_rol_CF", bus.CF, 1'b1);
    chk("tp_rol_OF", bus.OF, 1'b1);
    do_op(2'b11, 16'h0001, 8'd1, 1'b0, 1'b0);
    chk("tp_rcr_R", bus.R, 16'h0000);
    chk("tp_rcr_CF", bus.CF, 1'b1);
    do_op(2'b10, 16'h1234, 8'd17, 1'b1, 1'b0);
    chk("tp_rcl17_R", bus.R, 16'h1234);
    chk("tp_rcl17_CF", bus.CF, 1'b1);
    do_op(2'b01, 16'h0001, 8'd255, 1'b0, 1'b0);
    chk("tp_ror255_R", bus.R, 16'h0002);
    do_op(2'b00, 16'hBEEF, 8'd0, 1'b1, 1'b0);
    chk("tp_cnt0_R", bus.R, 16'hBEEF);
    chk("tp_cnt0_CF", bus.CF, 1'b1);
    chk("tp_cnt0_upd", bus.flag_upd, 1'b0);

    // start pulsed during RUN must be ignored
    do_op(2'b00, 16'hA5C3, 8'd8, 1'b0, 1'b1);

    // reset mid-RUN aborts without a done pulse
    @(negedge clk);
    bus.op = 2'b01; bus.A = 16'h1357; bus.count = 8'd10; bus.Cin = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_R", bus.R, 16'h0000);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_flags", {bus.CF, bus.OF, bus.flag_upd}, 3'b000);
    rst_n = 1'b1;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    do_op(2'b10, 16'hC0DE, 8'd5, 1'b1, 1'b0);

    // random ops, mostly short counts with some long ones
    for (int i = 0; i < 24; i++) begin
      rc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      do_op(2'($urandom), 16'($urandom), rc, 1'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
